// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the clocked NoC endpoints.
//   DR_SPACER / DR_ZERO / DR_ONE : dual-rail codes on a {rail1, rail0} pair
//   NOC_WID_DEF / ROUTE_WID_DEF  : default payload and routing widths
//   state_t                      : injector FSM states
package noc_pkg;

  localparam logic [1:0] DR_SPACER = 2'b00;
  localparam logic [1:0] DR_ZERO   = 2'b01;
  localparam logic [1:0] DR_ONE    = 2'b10;

  localparam int NOC_WID_DEF   = 16;
  localparam int ROUTE_WID_DEF = 4;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    DRIVE  = 2'd2,
    SPACER = 2'd3
  } state_t;

endpackage

// File: rtl/rx_injector_if.sv
// rx_injector_if: parallel packet handshake into the injector.
//   in_valid  packet offered (master -> slave)
//   in_ready  injector idle and able to accept (slave -> master)
//   in_route  routing bits, MSB consumed by the tree root
//   in_data   payload bits
interface rx_injector_if
  import noc_pkg::*;
#(
  parameter int NOC_WID   = NOC_WID_DEF,
  parameter int ROUTE_WID = ROUTE_WID_DEF
);

  logic                 in_valid;
  logic                 in_ready;
  logic [ROUTE_WID-1:0] in_route;
  logic [NOC_WID-1:0]   in_data;

  modport master (output in_valid, output in_route, output in_data, input in_ready);
  modport slave  (input in_valid, input in_route, input in_data, output in_ready);

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
//   clk    destination clock
//   rstn   asynchronous active-low reset; both flops load RST_VAL
//   d      asynchronous input
//   q      synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_injector.sv
// rx_injector: accepts one {route, payload} packet per valid/ready transfer
// and serialises it MSB-first onto a 4-phase return-to-zero dual-rail
// channel feeding the root of the RX request tree.
//   clk    sole clock
//   rstn   asynchronous active-low reset
//   up     packet handshake (slave side)
//   busy   packet in flight (DRIVE or SPACER)
//   pr     frame, high from the first bit to the end of the last spacer
//   pd     dual-rail bit: 00 spacer, 01 '0', 10 '1'
//   pa     asynchronous acknowledge from the tree root
module rx_injector
  import noc_pkg::*;
#(
  parameter int NOC_WID   = NOC_WID_DEF,
  parameter int ROUTE_WID = ROUTE_WID_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  rx_injector_if.slave  up,
  output logic          busy,
  output logic          pr,
  output logic [1:0]    pd,
  input  logic          pa
);

  localparam int TOT_W = ROUTE_WID + NOC_WID;
  localparam int CNT_W = $clog2(TOT_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOT_W - 1);

  function automatic logic [1:0] dr_code(input logic b);
    return b ? DR_ONE : DR_ZERO;
  endfunction

  state_t           state;
  logic [TOT_W-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             pa_s;

  // pa is driven by the self-timed tree; only the synchronised copy is used.
  // Resetting to 1 keeps the FSM in RESYNC until a low acknowledge is seen.
  sync_2ff #(.RST_VAL(1'b1)) u_pa_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (pa),
    .q    (pa_s)
  );

  // Control and all outputs are registered so the channel never glitches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= RESYNC;
      up.in_ready <= 1'b0;
      busy        <= 1'b0;
      pr          <= 1'b0;
      pd          <= DR_SPACER;
      cnt         <= '0;
    end else begin
      case (state)
        RESYNC: begin
          if (!pa_s) begin
            state       <= IDLE;
            up.in_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (up.in_valid && up.in_ready) begin
            state       <= DRIVE;
            up.in_ready <= 1'b0;
            busy        <= 1'b1;
            pr          <= 1'b1;
            pd          <= dr_code(up.in_route[ROUTE_WID-1]);
            cnt         <= '0;
          end
        end
        DRIVE: begin
          if (pa_s) begin
            state <= SPACER;
            pd    <= DR_SPACER;
          end
        end
        SPACER: begin
          if (!pa_s) begin
            if (cnt == LAST) begin
              state       <= IDLE;
              up.in_ready <= 1'b1;
              busy        <= 1'b0;
              pr          <= 1'b0;
            end else begin
              state <= DRIVE;
              cnt   <= cnt + 1'b1;
              // Next bit is the one about to become the MSB after the shift.
              pd    <= dr_code(sreg[TOT_W-2]);
            end
          end
        end
        default: begin
          state <= RESYNC;
        end
      endcase
    end
  end

  // Shift register is pure data: loaded at acceptance, shifted per spacer.
  always_ff @(posedge clk) begin
    if (state == IDLE && up.in_valid && up.in_ready) begin
      sreg <= {up.in_route, up.in_data};
    end else if (state == SPACER && !pa_s && cnt != LAST) begin
      sreg <= sreg << 1;
    end
  end

endmodule
